// File: rtl/hazard_tracker_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_tracker_pkg
// Description : Shared definitions for the hazard tracker: default register
//               identifier width, the zero-register constant and the
//               pipeline stage record (destination register + load flag).
// Revision    : 1.0 - initial release
// ============================================================================
package hazard_tracker_pkg;

  localparam int REG_ID_W = 7;

  // Register 0 is hard-wired; writes to it are never tracked.
  localparam logic [REG_ID_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [REG_ID_W-1:0] rd;
    logic                is_load;
  } stage_t;

endpackage
`default_nettype wire

// File: rtl/hazard_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_stage_reg
// Description : One pipeline stage register with hold, clear and load.
//               Priority: reset > hold > clear (bubble) > load.
// Ports       : clk   - clock
//               rst_n - synchronous active-low reset
//               hold  - keep current contents (pipeline frozen)
//               clear - insert a bubble (all zeros)
//               load  - capture d
//               d/q   - stage contents in / out
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_stage_reg
  import hazard_tracker_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         hold,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (hold) begin
      r_q <= r_q;
    end else if (clear) begin
      r_q <= '0;
    end else if (load) begin
      r_q <= d;
    end
  end

  assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/hazard_tracker.sv
`default_nettype none
// ============================================================================
// Module      : hazard_tracker
// Description : Tracks destination registers through EX/MEM/WB, detects the
//               load-use hazard in decode and counts load-use stall cycles.
//               Per-cycle priority: mem_wait > flush > load_use > advance.
// Ports       : clk, rst_n           - clock, synchronous active-low reset
//               rs1_d, rs2_d, rd_d   - decode-stage register identifiers
//               valid_d, we_d, load_d- decode-stage instruction qualifiers
//               flush                - kill the instruction leaving decode
//               mem_wait             - freeze the whole pipeline
//               rd_EX, rd_MEM, rd_WB - tracked destinations (0 = no write)
//               stall_d              - hold fetch/decode (combinational)
//               stall_cnt            - saturating load-use stall counter
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_tracker #(
  parameter int REG_ID_W = 7,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [REG_ID_W-1:0] rs1_d,
  input  logic [REG_ID_W-1:0] rs2_d,
  input  logic [REG_ID_W-1:0] rd_d,
  input  logic                valid_d,
  input  logic                we_d,
  input  logic                load_d,
  input  logic                flush,
  input  logic                mem_wait,
  output logic [REG_ID_W-1:0] rd_EX,
  output logic [REG_ID_W-1:0] rd_MEM,
  output logic [REG_ID_W-1:0] rd_WB,
  output logic                stall_d,
  output logic [CNT_W-1:0]    stall_cnt
);

  import hazard_tracker_pkg::*;

  localparam logic [REG_ID_W-1:0] c_rd_zero = '0;
  localparam logic [CNT_W-1:0]    c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

  // EX record packed as {rd, is_load}
  logic [REG_ID_W:0]   w_ex_d;
  logic [REG_ID_W:0]   w_ex_q;
  logic [REG_ID_W-1:0] w_rd_ex;
  logic                w_ld_ex;
  logic [REG_ID_W-1:0] w_rd_mem;
  logic [REG_ID_W-1:0] w_rd_wb;
  logic                w_load_use;
  logic                w_ex_bubble;
  logic                w_cnt_inc;
  logic [CNT_W-1:0]    r_stall_cnt;

  assign w_rd_ex = w_ex_q[REG_ID_W:1];
  assign w_ld_ex = w_ex_q[0];

  // Load flag is only set for a real, writing load to a non-zero register,
  // so a load to x0 can never raise a hazard later.
  assign w_ex_d[REG_ID_W:1] = (valid_d & we_d) ? rd_d : c_rd_zero;
  assign w_ex_d[0]          = valid_d & load_d & we_d & (rd_d != c_rd_zero);

  assign w_load_use = w_ld_ex & (w_rd_ex != c_rd_zero) & valid_d &
                      ((rs1_d == w_rd_ex) | (rs2_d == w_rd_ex));

  // Flush kills the dependent instruction, so it also suppresses the stall.
  assign w_ex_bubble = flush | w_load_use;
  assign stall_d     = mem_wait | (w_load_use & ~flush);
  assign w_cnt_inc   = w_load_use & ~flush & ~mem_wait & ~(&r_stall_cnt);

  hazard_stage_reg #(.W(REG_ID_W + 1)) u_stage_ex (
    .clk   (clk),
    .rst_n (rst_n),
    .hold  (mem_wait),
    .clear (w_ex_bubble),
    .load  (1'b1),
    .d     (w_ex_d),
    .q     (w_ex_q)
  );

  hazard_stage_reg #(.W(REG_ID_W)) u_stage_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .hold  (mem_wait),
    .clear (1'b0),
    .load  (1'b1),
    .d     (w_rd_ex),
    .q     (w_rd_mem)
  );

  hazard_stage_reg #(.W(REG_ID_W)) u_stage_wb (
    .clk   (clk),
    .rst_n (rst_n),
    .hold  (mem_wait),
    .clear (1'b0),
    .load  (1'b1),
    .d     (w_rd_mem),
    .q     (w_rd_wb)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (w_cnt_inc) begin
      r_stall_cnt <= r_stall_cnt + c_cnt_one;
    end
  end

  assign rd_EX     = w_rd_ex;
  assign rd_MEM    = w_rd_mem;
  assign rd_WB     = w_rd_wb;
  assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire
